soft_max: RTL and testbench
===========================

# soft_max

Classification output stage of the fully-connected (FC) module. It takes the final layer's LAYER_SIZE fixed-point scores and reports the index of the largest score as the predicted class (argmax, the decision a softmax would make). A combinational comparator tree feeds one output register, so a new score vector is accepted every cycle.

## Interface
- WORD_SIZE, 16: bit width of each score, two's-complement signed.
- LAYER_SIZE, 10: number of scores (classes); minimum 2.
- IDX_W, $clog2(LAYER_SIZE): derived, not overridable; width of the class index.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  X holds a valid score vector this cycle.
- X  input  [WORD_SIZE-1:0] x LAYER_SIZE (unpacked array)  score vector; element k is class k.
- Z  output  IDX_W  index of the maximum score.
- out_valid  output  1  Z holds the result for a vector accepted in the previous cycle.
- max_val  output  WORD_SIZE  winning score; present only with SOFT_MAX_MAXVAL_EN.

## Operation
- Compare scores as signed values: 16'h8000 is the most negative, 16'h7FFF the most positive.
- Z = the smallest k such that X[k] >= X[j] for all j. On ties, the lowest index wins.
- Use a balanced binary tree of compare-select nodes.
  - Each node passes (value, index) pairs.
  - It forwards the right input only if right.value > left.value (strictly greater).
  - The left input always carries the lower indices.
- If LAYER_SIZE is not a power of two, pass the unpaired leaf through unchanged. Do not pad it with a dummy value.
- Index values LAYER_SIZE .. 2^IDX_W-1 are never produced.
- Comparisons are full-width. There is no scaling, saturation or exponent computation.

## Timing
- Latency is 1 cycle.
  - A vector sampled with in_valid=1 at edge n appears on Z, with out_valid=1, after edge n.
  - Both stay stable until edge n+1.
- Throughput is one vector per clock. There is no backpressure and no ready signal.
- When in_valid=0 at an edge:
  - out_valid goes to 0 for the following cycle.
  - Z (and max_val) hold their previous values.
- Reset: when reset=0 at an edge, Z=0, out_valid=0 and max_val=0 after that edge, regardless of in_valid.
- Reset asserted mid-stream drops the in-flight result.
- The first vector sampled after reset deasserts gets normal 1-cycle latency.
- X may change every cycle. Only the value present at the sampling edge matters.

## Configuration
- SOFT_MAX_MAXVAL_EN defined:
  - Adds output port max_val (WORD_SIZE bits).
  - max_val is registered alongside Z and carries the winning score under the same valid, hold and reset rules.
- SOFT_MAX_MAXVAL_EN not defined:
  - The port does not exist.
  - The tree still carries values internally, but only the index is registered.

## Structure
- Package soft_max_pkg holds:
  - default WORD_SIZE and LAYER_SIZE constants;
  - a helper function for the index width;
  - a typedef for the (value, index) candidate struct, parameterised through the package defaults.
- Sub-module soft_max_cmp: one compare-select node taking two candidates and producing one, with the strict-greater, lower-index-wins rule.
- The top level generates the tree levels, the output register and the valid register.

## Test plan
Defaults used throughout: WORD_SIZE=16, LAYER_SIZE=10.
- Reset: hold reset=0 for 3 edges with arbitrary X and in_valid=1 -> Z=0, out_valid=0 each cycle; first vector after release appears 1 cycle later.
- Single peak: X[k]=16'h0100, all others 16'h0001, one vector each for k=0..9 back-to-back -> Z=k one cycle after each, out_valid=1 throughout.
- Signed handling: X[3]=16'hFFFF (-1), X[7]=16'h8000, others 16'hFF00 -> Z=3. Then all 16'h8000 except X[9]=16'h7FFF -> Z=9.
- Ties: X[2]=X[5]=X[8]=16'h0500, others 0 -> Z=2. All elements equal -> Z=0.
- Valid gaps: in_valid pattern 1,0,1 with distinct argmaxes 4, –, 6 -> out_valid 1,0,1; Z reads 4,4,6.
- Config: with SOFT_MAX_MAXVAL_EN, X[6]=16'h1234 as the max -> max_val=16'h1234 with Z=6. Random regression of 1000 vectors against a reference argmax model, both builds.

Source files
------------

// File: rtl/soft_max_pkg.sv
// -----------------------------------------------------------------------------
// soft_max_pkg
// Shared definitions for the FC classification output stage (argmax).
//   SM_WORD_SIZE   default score width (two's-complement signed)
//   SM_LAYER_SIZE  default number of classes
//   idx_width()    width of a class index for a given class count
//   cand_t         (value, index) candidate carried through the compare tree
// -----------------------------------------------------------------------------
package soft_max_pkg;

    localparam int SM_WORD_SIZE  = 16;
    localparam int SM_LAYER_SIZE = 10;

    // Class-index width; callers guarantee n >= 2 so the result is never 0.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    localparam int SM_IDX_W = idx_width(SM_LAYER_SIZE);

    typedef struct packed {
        logic [SM_WORD_SIZE-1:0] value;
        logic [SM_IDX_W-1:0]     idx;
    } cand_t;

endpackage

// File: rtl/soft_max_cmp.sv
// -----------------------------------------------------------------------------
// soft_max_cmp
// One compare-select node of the argmax tree.
//   a_i  left candidate (always carries the lower class indices)
//   b_i  right candidate
//   y_o  winner: b_i only when its value is strictly greater than a_i's,
//        so equal values resolve to the lower index.
// Values are compared as two's-complement signed numbers, full width.
// -----------------------------------------------------------------------------
module soft_max_cmp
    import soft_max_pkg::*;
#(
    parameter type node_t = cand_t
) (
    input  node_t a_i,
    input  node_t b_i,
    output node_t y_o
);

    // Strict-greater select keeps the left (lower-index) side on ties.
    always_comb begin
        y_o = a_i;
        if ($signed(b_i.value) > $signed(a_i.value)) begin
            y_o = b_i;
        end else begin
            y_o = a_i;
        end
    end

endmodule

// File: rtl/soft_max.sv
// -----------------------------------------------------------------------------
// soft_max
// Classification output stage: reports the index of the largest signed score
// (lowest index on ties) one cycle after a vector is accepted.
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   in_valid   X holds a valid score vector this cycle
//   X          LAYER_SIZE scores of WORD_SIZE bits, element k is class k
//   Z          index of the maximum score (registered)
//   out_valid  Z holds the result of the vector accepted on the previous edge
//   max_val    winning score (registered), only with SOFT_MAX_MAXVAL_EN
// Optional feature macro: SOFT_MAX_MAXVAL_EN adds the max_val output.
// A balanced combinational compare tree feeds a single output register, so a
// new vector can be accepted every cycle. When in_valid is low the results
// hold and out_valid drops.
// -----------------------------------------------------------------------------
module soft_max
    import soft_max_pkg::*;
#(
    parameter int WORD_SIZE  = SM_WORD_SIZE,
    parameter int LAYER_SIZE = SM_LAYER_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [WORD_SIZE-1:0]             X [LAYER_SIZE],
`ifdef SOFT_MAX_MAXVAL_EN
    output logic [WORD_SIZE-1:0]             max_val,
`endif
    output logic [idx_width(LAYER_SIZE)-1:0] Z,
    output logic                             out_valid
);

    localparam int IDX_W  = idx_width(LAYER_SIZE);
    localparam int LEVELS = IDX_W;

    typedef struct packed {
        logic [WORD_SIZE-1:0] value;
        logic [IDX_W-1:0]     idx;
    } node_t;

    // Number of nodes on tree level l (level 0 = leaves); the unpaired node
    // of an odd level is carried up unchanged, hence the ceiling.
    function automatic int lvl_cnt(input int l);
        return (LAYER_SIZE + (1 << l) - 1) >> l;
    endfunction

    // Position of the first node of level l in the flat node array.
    function automatic int lvl_off(input int l);
        int s;
        s = 0;
        for (int i = 0; i < l; i++) begin
            s += lvl_cnt(i);
        end
        return s;
    endfunction

    localparam int N_NODES = lvl_off(LEVELS) + 1;
    localparam int ROOT    = N_NODES - 1;

    // All tree nodes, level by level; the last entry is the root.
    node_t node_s [N_NODES];

    for (genvar k = 0; k < LAYER_SIZE; k++) begin : g_leaf
        assign node_s[k] = '{value: X[k], idx: IDX_W'(k)};
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar j = 0; j < lvl_cnt(l + 1); j++) begin : g_node
            if (2 * j + 1 < lvl_cnt(l)) begin : g_cmp
                soft_max_cmp #(
                    .node_t (node_t)
                ) u_cmp (
                    .a_i (node_s[lvl_off(l) + 2 * j]),
                    .b_i (node_s[lvl_off(l) + 2 * j + 1]),
                    .y_o (node_s[lvl_off(l + 1) + j])
                );
            end else begin : g_pass
                assign node_s[lvl_off(l + 1) + j] = node_s[lvl_off(l) + 2 * j];
            end
        end
    end

    logic [IDX_W-1:0] z_q, z_d;
    logic             valid_q, valid_d;
`ifdef SOFT_MAX_MAXVAL_EN
    logic [WORD_SIZE-1:0] max_q, max_d;
`endif

    // Next-state: reset clears, a valid vector loads the root, otherwise hold.
    always_comb begin
        z_d     = z_q;
        valid_d = 1'b0;
`ifdef SOFT_MAX_MAXVAL_EN
        max_d   = max_q;
`endif
        if (!reset) begin
            z_d     = '0;
            valid_d = 1'b0;
`ifdef SOFT_MAX_MAXVAL_EN
            max_d   = '0;
`endif
        end else if (in_valid) begin
            z_d     = node_s[ROOT].idx;
            valid_d = 1'b1;
`ifdef SOFT_MAX_MAXVAL_EN
            max_d   = node_s[ROOT].value;
`endif
        end else begin
            z_d     = z_q;
            valid_d = 1'b0;
`ifdef SOFT_MAX_MAXVAL_EN
            max_d   = max_q;
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        z_q     <= z_d;
        valid_q <= valid_d;
`ifdef SOFT_MAX_MAXVAL_EN
        max_q   <= max_d;
`endif
    end

    assign Z         = z_q;
    assign out_valid = valid_q;
`ifdef SOFT_MAX_MAXVAL_EN
    assign max_val   = max_q;
`endif

endmodule

// File: tb/tb_soft_max.sv
// -----------------------------------------------------------------------------
// tb_soft_max
// Directed and random stimulus for soft_max with a scoreboard queue: every
// driven cycle pushes the expected registered outputs, which are popped and
// compared one edge later. Build with SOFT_MAX_MAXVAL_EN to also cover max_val.
// -----------------------------------------------------------------------------
module tb_soft_max;
    import soft_max_pkg::*;

    localparam int W  = SM_WORD_SIZE;
    localparam int N  = SM_LAYER_SIZE;
    localparam int IW = idx_width(N);

    typedef struct {
        logic          v;
        logic [IW-1:0] z;
        logic [W-1:0]  m;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  X [N];
    logic [IW-1:0] Z;
    logic          out_valid;
`ifdef SOFT_MAX_MAXVAL_EN
    logic [W-1:0]  max_val;
`endif

    exp_t          sb_q [$];
    logic [IW-1:0] mdl_z = '0;
    logic [W-1:0]  mdl_m = '0;
    int            errors = 0;
    int            checks = 0;

    soft_max dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .X         (X),
`ifdef SOFT_MAX_MAXVAL_EN
        .max_val   (max_val),
`endif
        .Z         (Z),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Linear-scan reference: first index holding the signed maximum.
    function automatic int ref_argmax();
        int best;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if ($signed(X[k]) > $signed(X[best])) best = k;
        end
        return best;
    endfunction

    // Drive one cycle, push its expectation, compare after the edge.
    task automatic cyc(input logic rst_n, input logic v, input string tag);
        exp_t e;
        exp_t got;
        int   a;
        reset    = rst_n;
        in_valid = v;
        if (!rst_n) begin
            mdl_z = '0;
            mdl_m = '0;
            e.v   = 1'b0;
        end else if (v) begin
            a     = ref_argmax();
            mdl_z = IW'(a);
            mdl_m = X[a];
            e.v   = 1'b1;
        end else begin
            e.v   = 1'b0;
        end
        e.z = mdl_z;
        e.m = mdl_m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (out_valid === got.v) else begin
            errors++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, got.v);
        end
        checks++;
        assert (Z === got.z) else begin
            errors++;
            $error("FAIL %s Z observed=%0d expected=%0d", tag, Z, got.z);
        end
`ifdef SOFT_MAX_MAXVAL_EN
        checks++;
        assert (max_val === got.m) else begin
            errors++;
            $error("FAIL %s max_val observed=%h expected=%h", tag, max_val, got.m);
        end
`endif
    endtask

    task automatic fill(input logic [W-1:0] val);
        for (int k = 0; k < N; k++) X[k] = val;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        fill(16'h0000);

        // Reset held for 3 edges with valid input present.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < N; k++) X[k] = W'($urandom);
            cyc(1'b0, 1'b1, "reset");
        end

        // Single peak walking 0..9, back-to-back; the first follows release.
        for (int p = 0; p < N; p++) begin
            fill(16'h0001);
            X[p] = 16'h0100;
            cyc(1'b1, 1'b1, "peak");
        end

        // Signed handling.
        fill(16'hFF00);
        X[3] = 16'hFFFF;
        X[7] = 16'h8000;
        cyc(1'b1, 1'b1, "signed_neg");
        fill(16'h8000);
        X[9] = 16'h7FFF;
        cyc(1'b1, 1'b1, "signed_ext");

        // Ties resolve to the lowest index.
        fill(16'h0000);
        X[2] = 16'h0500;
        X[5] = 16'h0500;
        X[8] = 16'h0500;
        cyc(1'b1, 1'b1, "tie3");
        fill(16'h1234);
        cyc(1'b1, 1'b1, "tie_all");

        // Valid gap: the ignored vector has a different argmax.
        fill(16'h0010);
        X[4] = 16'h0200;
        cyc(1'b1, 1'b1, "gap_a");
        fill(16'h0010);
        X[1] = 16'h0300;
        cyc(1'b1, 1'b0, "gap_hold");
        fill(16'h0010);
        X[6] = 16'h0400;
        cyc(1'b1, 1'b1, "gap_b");

        // Maximum value carried along with the index.
        fill(16'h0100);
        X[6] = 16'h1234;
        cyc(1'b1, 1'b1, "maxval");

        // Reset mid-stream drops the in-flight vector; then hold at zero.
        fill(16'h0000);
        X[8] = 16'h0777;
        cyc(1'b0, 1'b1, "mid_reset");
        cyc(1'b1, 1'b0, "post_reset_hold");
        cyc(1'b1, 1'b1, "post_reset_vec");

        // Random regression; half the vectors use a narrow range to force ties.
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (i % 2 == 0) X[k] = W'($urandom);
                else            X[k] = W'($urandom_range(0, 3)) - 16'h0001;
            end
            cyc(1'b1, ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
